// File: rtl/bullet_pkg.sv
// bullet_pkg: bullet RAM record layout, direction codes and FSM states,
// shared with the VGA renderer that unpacks the same 32-bit words.
package bullet_pkg;
  localparam int X_LSB = 23;
  localparam int Y_LSB = 14;
  localparam int ACT_BIT = 5;
  localparam int DIR_LSB = 3;
  localparam logic [1:0] DIR_UP = 2'b00;
  localparam logic [1:0] DIR_DOWN = 2'b01;
  localparam logic [1:0] DIR_LEFT = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ALLOC, S_SWEEP} state_t;
  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [7:0] pad_hi;
    logic       active;
    logic [1:0] dir;
    logic [2:0] pad_lo;
  } bullet_rec_t;
  // Inactive slots always pack to all zeros so the renderer can skip them.
  function automatic bullet_rec_t pack_rec(logic [8:0] x, logic [8:0] y, logic [1:0] dir, logic active);
    return active ? bullet_rec_t'({x, y, 8'd0, 1'b1, dir, 3'd0}) : '0;
  endfunction
  function automatic bullet_rec_t unpack_rec(logic [31:0] w);
    return pack_rec(w[X_LSB +: 9], w[Y_LSB +: 9], w[DIR_LSB +: 2], w[ACT_BIT]);
  endfunction
endpackage

// File: rtl/bullet_table_writer_if.sv
// bullet_table_writer_if: fire request handshake and bullet RAM write port.
interface bullet_table_writer_if #(parameter int MAX_BULLETS = 64);
  localparam int ADDR_W = $clog2(MAX_BULLETS);
  logic              fire_valid;
  logic              fire_ready;
  logic [8:0]        fire_x;
  logic [8:0]        fire_y;
  logic [1:0]        fire_dir;
  logic              fire_dropped;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  modport master(output fire_valid, fire_x, fire_y, fire_dir,
                 input fire_ready, fire_dropped, ram_we, ram_addr, ram_wdata);
  modport slave(input fire_valid, fire_x, fire_y, fire_dir,
                output fire_ready, fire_dropped, ram_we, ram_addr, ram_wdata);
endinterface

// File: rtl/bullet_slot_finder.sv
// bullet_slot_finder: lowest-index inactive slot priority encoder.
module bullet_slot_finder #(parameter int N = 64) (
  input  logic [N-1:0]         active,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  assign found = ~&active;
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = active[i] ? idx : W'(i);
  end
endmodule

// File: rtl/bullet_table_writer.sv
// bullet_table_writer: owns the bullet slot table, allocates fired bullets,
// advances them once per frame and mirrors every touched slot into the bullet RAM.
module bullet_table_writer
  import bullet_pkg::*;
#(
  parameter int MAX_BULLETS = 64,
  parameter int BULLET_SIZE = 8,
  parameter int SPEED       = 4,
  parameter int X_LIMIT     = 512 - BULLET_SIZE,
  parameter int Y_LIMIT     = 480 - BULLET_SIZE
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             frame_tick,
  bullet_table_writer_if.slave             bus,
  output logic [$clog2(MAX_BULLETS+1)-1:0] active_count,
  output logic                             busy
);
  localparam int ADDR_W = $clog2(MAX_BULLETS);
  state_t                   state;
  logic [ADDR_W-1:0]        idx, free_idx;
  logic                     found, last, off;
  logic [MAX_BULLETS-1:0]   act;
  logic [8:0]               xs [MAX_BULLETS];
  logic [8:0]               ys [MAX_BULLETS];
  logic [1:0]               ds [MAX_BULLETS];
  logic [8:0]               req_x, req_y;
  logic [1:0]               req_dir;
  logic [2:0]               sync;
  logic                     tick_pending;
  logic [9:0]               cx, cy, nx, ny;
  bullet_slot_finder #(.N(MAX_BULLETS)) finder (.active(act), .found(found), .idx(free_idx));
  assign bus.fire_ready = state == S_IDLE && !tick_pending;
  assign busy = state == S_CLEAR || state == S_SWEEP;
  assign last = idx == ADDR_W'(MAX_BULLETS - 1);
  // 10-bit signed move so that stepping past either edge is seen as out of range, never wrapped.
  assign cx = {1'b0, xs[idx]};
  assign cy = {1'b0, ys[idx]};
  assign nx = ds[idx] == DIR_LEFT ? cx - 10'(SPEED) : ds[idx] == DIR_RIGHT ? cx + 10'(SPEED) : cx;
  assign ny = ds[idx] == DIR_UP ? cy - 10'(SPEED) : ds[idx] == DIR_DOWN ? cy + 10'(SPEED) : cy;
  assign off = $signed(nx) < 10'sd0 || $signed(nx) > $signed(10'(X_LIMIT)) ||
               $signed(ny) < 10'sd0 || $signed(ny) > $signed(10'(Y_LIMIT));
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= S_CLEAR;
      idx <= '0;
      act <= '0;
      for (int i = 0; i < MAX_BULLETS; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
        ds[i] <= '0;
      end
      req_x <= '0;
      req_y <= '0;
      req_dir <= '0;
      sync <= '0;
      tick_pending <= 1'b0;
      active_count <= '0;
      bus.ram_we <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
      bus.fire_dropped <= 1'b0;
    end else begin
      sync <= {sync[1:0], frame_tick};
      // A new edge wins over the clear that happens when IDLE hands off to SWEEP.
      tick_pending <= (sync[1] & ~sync[2]) | (tick_pending & state != S_IDLE);
      bus.ram_we <= 1'b0;
      bus.fire_dropped <= 1'b0;
      case (state)
        S_CLEAR: begin
          bus.ram_we <= 1'b1;
          bus.ram_addr <= idx;
          bus.ram_wdata <= '0;
          idx <= last ? '0 : idx + 1'b1;
          state <= last ? S_IDLE : S_CLEAR;
        end
        S_IDLE:
          if (tick_pending) begin
            idx <= '0;
            state <= S_SWEEP;
          end else if (bus.fire_valid) begin
            req_x <= bus.fire_x;
            req_y <= bus.fire_y;
            req_dir <= bus.fire_dir;
            state <= S_ALLOC;
          end
        S_ALLOC: begin
          state <= S_IDLE;
          if (found) begin
            act[free_idx] <= 1'b1;
            xs[free_idx] <= req_x;
            ys[free_idx] <= req_y;
            ds[free_idx] <= req_dir;
            bus.ram_we <= 1'b1;
            bus.ram_addr <= free_idx;
            bus.ram_wdata <= pack_rec(req_x, req_y, req_dir, 1'b1);
            active_count <= active_count + 1'b1;
          end else bus.fire_dropped <= 1'b1;
        end
        S_SWEEP: begin
          bus.ram_we <= 1'b1;
          bus.ram_addr <= idx;
          bus.ram_wdata <= '0;
          idx <= last ? '0 : idx + 1'b1;
          state <= last ? S_IDLE : S_SWEEP;
          if (act[idx] && off) begin
            act[idx] <= 1'b0;
            active_count <= active_count - 1'b1;
          end else if (act[idx]) begin
            xs[idx] <= nx[8:0];
            ys[idx] <= ny[8:0];
            bus.ram_wdata <= pack_rec(nx[8:0], ny[8:0], ds[idx], 1'b1);
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
endmodule

// File: tb/tb_bullet_table_writer.sv
// tb_bullet_table_writer: scoreboard of expected RAM writes built from a slot-table
// model, a fire vector table, and hand sequences for sweep/drop/reset corners.
module tb_bullet_table_writer;
  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [8:0] x; logic [8:0] y; logic [1:0] d; int a; } vec_t;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic [6:0]  active_count;
  logic        busy;
  wr_t         q[$];
  int          vecs = 0;
  int          miscs = 0;
  logic [8:0]  mx[64];
  logic [8:0]  my[64];
  logic [1:0]  md[64];
  bit          mact[64];
  int          mcnt = 0;
  vec_t        tbl[8];
  always #5 clk = ~clk;
  bullet_table_writer_if #(.MAX_BULLETS(64)) bus();
  bullet_table_writer dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .bus(bus), .active_count(active_count), .busy(busy)
  );

  function automatic logic [31:0] rec(logic [8:0] x, logic [8:0] y, logic [1:0] d);
    return {x, y, 8'd0, 1'b1, d, 3'd0};
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscs++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  task automatic bad(string n);
    vecs++;
    miscs++;
    $display("FAIL %s: event did not occur within its cycle budget", n);
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (bus.ram_we === 1'b1) begin
      if (q.size() == 0) begin
        vecs++;
        miscs++;
        $display("FAIL unexpected_write: addr %0d data %h, expected no write", bus.ram_addr, bus.ram_wdata);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(bus.ram_addr), 32'(e.a));
        chk("wr_data", bus.ram_wdata, e.d);
      end
    end
  end

  task automatic model_alloc(input logic [8:0] x, input logic [8:0] y, input logic [1:0] d,
                             output bit drop, output int a);
    drop = 1'b1;
    a = 0;
    for (int i = 0; i < 64; i++)
      if (!mact[i]) begin
        a = i;
        drop = 1'b0;
        break;
      end
    if (!drop) begin
      mact[a] = 1'b1;
      mx[a] = x;
      my[a] = y;
      md[a] = d;
      mcnt++;
    end
  endtask

  task automatic model_sweep();
    int nx, ny;
    for (int i = 0; i < 64; i++) begin
      if (!mact[i]) q.push_back('{6'(i), 32'd0});
      else begin
        nx = int'(mx[i]);
        ny = int'(my[i]);
        if (md[i] == 2'd0) ny -= 4;
        else if (md[i] == 2'd1) ny += 4;
        else if (md[i] == 2'd2) nx -= 4;
        else nx += 4;
        if (nx < 0 || nx > 504 || ny < 0 || ny > 472) begin
          mact[i] = 1'b0;
          mcnt--;
          q.push_back('{6'(i), 32'd0});
        end else begin
          mx[i] = 9'(nx);
          my[i] = 9'(ny);
          q.push_back('{6'(i), rec(mx[i], my[i], md[i])});
        end
      end
    end
  endtask

  task automatic fire(input logic [8:0] x, input logic [8:0] y, input logic [1:0] d,
                      input bit drop, input int a, input logic [31:0] w);
    int n = 0;
    if (!drop) q.push_back('{6'(a), w});
    bus.fire_valid = 1'b1;
    bus.fire_x = x;
    bus.fire_y = y;
    bus.fire_dir = d;
    while (bus.fire_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      bad("fire_accept");
      bus.fire_valid = 1'b0;
      return;
    end
    chk("busy_at_accept", 32'(busy), 32'd0);
    @(negedge clk);
    bus.fire_valid = 1'b0;
    @(negedge clk);
    chk("fire_dropped", 32'(bus.fire_dropped), 32'(drop));
    chk("count_after_fire", 32'(active_count), 32'(mcnt));
  endtask

  task automatic do_reset();
    int n = 0;
    #1 resetn = 1'b0;
    q.delete();
    foreach (mact[i]) mact[i] = 1'b0;
    mcnt = 0;
    @(negedge clk);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ready", 32'(bus.fire_ready), 32'd0);
    chk("rst_dropped", 32'(bus.fire_dropped), 32'd0);
    chk("rst_count", 32'(active_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 64; i++) q.push_back('{6'(i), 32'd0});
    resetn = 1'b1;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bad("clear_done");
    #1;
    chk("ready_after_clear", 32'(bus.fire_ready), 32'd1);
    chk("clear_writes_done", 32'(q.size()), 32'd0);
  endtask

  task automatic do_tick();
    int n = 0;
    model_sweep();
    frame_tick = 1'b1;
    repeat (4) @(negedge clk);
    frame_tick = 1'b0;
    chk("busy_in_sweep", 32'(busy), 32'd1);
    chk("ready_in_sweep", 32'(bus.fire_ready), 32'd0);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bad("sweep_done");
    #1;
    chk("sweep_writes_done", 32'(q.size()), 32'd0);
    chk("count_after_sweep", 32'(active_count), 32'(mcnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drop;
    int a, n;
    bus.fire_valid = 1'b0;
    bus.fire_x = '0;
    bus.fire_y = '0;
    bus.fire_dir = '0;
    tbl[0] = '{9'd100, 9'd200, 2'd3, 0};
    tbl[1] = '{9'd502, 9'd50,  2'd3, 1};
    tbl[2] = '{9'd10,  9'd2,   2'd0, 2};
    tbl[3] = '{9'd2,   9'd300, 2'd2, 3};
    tbl[4] = '{9'd200, 9'd470, 2'd1, 4};
    tbl[5] = '{9'd300, 9'd468, 2'd1, 5};
    tbl[6] = '{9'd4,   9'd100, 2'd2, 6};
    tbl[7] = '{9'd500, 9'd100, 2'd3, 7};
    do_reset();
    foreach (tbl[i]) begin
      model_alloc(tbl[i].x, tbl[i].y, tbl[i].d, drop, a);
      fire(tbl[i].x, tbl[i].y, tbl[i].d, 1'b0, tbl[i].a,
           {tbl[i].x, tbl[i].y, 8'd0, 1'b1, tbl[i].d, 3'b000});
    end
    do_tick();
    chk("count_after_retire", 32'(active_count), 32'd4);
    for (int i = 0; mcnt < 64 && i < 100; i++) begin
      model_alloc(9'(20 + i * 7), 9'((i * 13) % 460 + 4), 2'(i % 4), drop, a);
      fire(9'(20 + i * 7), 9'((i * 13) % 460 + 4), 2'(i % 4), drop, a,
           rec(9'(20 + i * 7), 9'((i * 13) % 460 + 4), 2'(i % 4)));
    end
    model_alloc(9'd1, 9'd1, 2'd0, drop, a);
    fire(9'd1, 9'd1, 2'd0, 1'b1, 0, 32'd0);
    @(negedge clk);
    chk("dropped_single_pulse", 32'(bus.fire_dropped), 32'd0);
    chk("count_full", 32'(active_count), 32'd64);
    model_sweep();
    frame_tick = 1'b1;
    repeat (3) @(negedge clk);
    frame_tick = 1'b0;
    chk("tick_beats_fire_ready", 32'(bus.fire_ready), 32'd0);
    model_alloc(9'd50, 9'd60, 2'd3, drop, a);
    fire(9'd50, 9'd60, 2'd3, drop, a, rec(9'd50, 9'd60, 2'd3));
    #1;
    chk("sweep_then_alloc_done", 32'(q.size()), 32'd0);
    model_sweep();
    frame_tick = 1'b1;
    repeat (4) @(negedge clk);
    frame_tick = 1'b0;
    n = 0;
    while (!(bus.ram_we === 1'b1 && bus.ram_addr == 6'd10) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) bad("mid_sweep_addr10");
    do_reset();
    model_alloc(9'd7, 9'd9, 2'd1, drop, a);
    fire(9'd7, 9'd9, 2'd1, drop, a, rec(9'd7, 9'd9, 2'd1));
    repeat (2) @(negedge clk);
    #1;
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscs);
    $finish;
  end
endmodule
